// File: rtl/rotate_sequencer.sv
// Multi-cycle rotate/logical-shift sequencer built around a one-bit step datapath.
// Operands are latched on an accepted START; DONE strobes for one cycle with the result on Y.
module rotate_sequencer #(
    parameter int N  = 8,
    parameter int CW = $clog2(N)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic          DIR,
    input  logic          SHIFT,
    input  logic [CW-1:0] AMT,
    input  logic [N-1:0]  X,
    output logic [N-1:0]  Y,
    output logic          BUSY,
    output logic          DONE
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  y_q, y_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;
    logic          shift_q, shift_d;

    logic          fill_r, fill_l;
    logic [N-1:0]  step_y;

    // Bit wrapped in by a rotate, or zero when shifting.
    assign fill_r = shift_q ? 1'b0 : y_q[0];
    assign fill_l = shift_q ? 1'b0 : y_q[N-1];
    assign step_y = dir_q ? {fill_r, y_q[N-1:1]} : {y_q[N-2:0], fill_l};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            y_q     <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            shift_q <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    y_d     = X;
                    cnt_d   = AMT;
                    dir_d   = DIR;
                    shift_d = SHIFT;
                    state_d = (AMT != '0) ? RUN : FINISH;
                end
            end
            RUN: begin
                y_d   = step_y;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        Y    = y_q;
        BUSY = (state_q != IDLE);
        DONE = (state_q == FINISH);
    end

endmodule
